mul8_seq: RTL and testbench



---
 rtl/mul8_seq.sv | 128 ++++++++++++
 tb/tb_mul8_seq.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul8_seq.sv
// Sequential shift-and-add unsigned multiplier, W x W -> 2W; define MUL_ADD_REM_EN to add port r so p = a*b + r.
// Latency: fixed W RUN cycles; out_valid is seen by the edge T+W+1 after acceptance on edge T (W+2 cycles per op minimum).
// Backpressure: DONE holds p/out_valid until out_ready; in_ready stays low from acceptance until after the output handshake.
module mul8_seq #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
`ifdef MUL_ADD_REM_EN
    input  logic [W-1:0]   r,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] p,
    output logic           busy
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [2*W-1:0]  mcand;
    logic [2*W-1:0]  acc;
    logic [2*W-1:0]  acc_step;
    logic [2*W-1:0]  acc_init;
    logic [W-1:0]    mplier;
    logic [CW-1:0]   cnt;
    logic            last;
    logic            accept;

    // Accumulator seed: the addend when the multiply-add build is enabled, else zero.
`ifdef MUL_ADD_REM_EN
    assign acc_init = {{W{1'b0}}, r};
`else
    assign acc_init = '0;
`endif

    // One shift-and-add iteration; the sum cannot exceed 2W bits.
    assign acc_step = mplier[0] ? (acc + mcand) : acc;
    assign last     = (cnt == CW'(W - 1));

    // State register with synchronous reset; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs decoded from the current state.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: operands latched only at acceptance, then W fixed iterations; p loads once on the final one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            p      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        mcand  <= {{W{1'b0}}, a};
                        mplier <= b;
                        acc    <= acc_init;
                        cnt    <= '0;
                    end
                end
                S_RUN: begin
                    acc    <= acc_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        p <= acc_step;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul8_seq.sv
// Self-checking bench for mul8_seq: scoreboard queue of expected products, one task per scenario.
// Latency: ops complete within a bounded cycle budget; an expired budget is reported as a failure.
// Backpressure: exercised by holding out_ready low while a result waits in DONE.
module tb_mul8_seq;

    localparam int W = 8;
`ifdef MUL_ADD_REM_EN
    localparam bit ADDREM = 1'b1;
`else
    localparam bit ADDREM = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   a;
    logic [7:0]   b;
    logic [7:0]   r;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  p;
    logic         busy;

    logic [15:0]  exp_q[$];
    int           checks   = 0;
    int           failures = 0;

    mul8_seq #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef MUL_ADD_REM_EN
        .r         (r),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [15:0] model(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] rv);
        logic [15:0] prod;
        prod = {8'h00, av} * {8'h00, bv};
        if (ADDREM) prod = prod + {8'h00, rv};
        return prod;
    endfunction

    // Present one operand set for a single cycle (caller has seen in_ready high) and record the expected result.
    task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] rv);
        in_valid = 1'b1;
        a = av;
        b = bv;
        r = rv;
        exp_q.push_back(model(av, bv, rv));
        tick();
        in_valid = 1'b0;
    endtask

    // Count edges after acceptance until out_valid is seen; ok=0 if the budget expires.
    task automatic wait_out(output int edges, output bit ok);
        edges = 0;
        while (!out_valid && edges < 100) begin
            tick();
            edges++;
        end
        ok = out_valid;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (p !== 16'h0000) begin failures++; $display("FAIL reset_p: got %h want 0000", p); end
        rst_n = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic;
        int          edges;
        bit          ok;
        logic [15:0] e;
        out_ready = 1'b1;
        send(8'hFF, 8'hFF, 8'h00);
        checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL basic_accept: in_ready=%b busy=%b want 0/1", in_ready, busy); end
        wait_out(edges, ok);
        checks++; if (!ok) begin failures++; $display("FAIL basic_timeout: out_valid never rose"); end
        checks++; if (edges + 1 != W + 1) begin failures++; $display("FAIL basic_latency: got %0d edges want %0d", edges + 1, W + 1); end
        e = exp_q.pop_front();
        checks++; if (p !== e) begin failures++; $display("FAIL basic_p: got %h want %h", p, e); end
        checks++; if (p !== 16'hFE01) begin failures++; $display("FAIL basic_p_const: got %h want fe01", p); end
        tick();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL basic_return_idle: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    endtask

    task automatic test_zero_identity;
        logic [7:0]  av[2];
        logic [7:0]  bv[2];
        int          edges;
        bit          ok;
        logic [15:0] e;
        av[0] = 8'h00; bv[0] = 8'h5A;
        av[1] = 8'h5A; bv[1] = 8'h01;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            send(av[i], bv[i], 8'h00);
            wait_out(edges, ok);
            checks++; if (!ok || edges + 1 != W + 1) begin failures++; $display("FAIL zero_ident_latency[%0d]: got %0d edges want %0d", i, edges + 1, W + 1); end
            e = exp_q.pop_front();
            checks++; if (p !== e) begin failures++; $display("FAIL zero_ident_p[%0d]: got %h want %h", i, p, e); end
            tick();
        end
    endtask

    task automatic test_backpressure;
        int          edges;
        bit          ok;
        logic [15:0] e;
        out_ready = 1'b0;
        send(8'h12, 8'h34, 8'h00);
        wait_out(edges, ok);
        checks++; if (!ok) begin failures++; $display("FAIL bp_timeout: out_valid never rose"); end
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a = 8'h77;
            b = 8'h77;
            checks++; if (p !== e || p !== 16'h03A8) begin failures++; $display("FAIL bp_hold_p[%0d]: got %h want %h", i, p, e); end
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_hs[%0d]: out_valid=%b in_ready=%b want 1/0", i, out_valid, in_ready); end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_no_queued_op: busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid_run;
        int          edges;
        bit          ok;
        int          highs;
        logic [15:0] e;
        out_ready = 1'b1;
        send(8'hAB, 8'hCD, 8'h00);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        void'(exp_q.pop_back());
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || p !== 16'h0000) begin
            failures++; $display("FAIL midrun_reset_state: out_valid=%b in_ready=%b busy=%b p=%h want 0/1/0/0000", out_valid, in_ready, busy, p);
        end
        rst_n = 1'b1;
        highs = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) highs++;
            tick();
        end
        checks++; if (highs != 0) begin failures++; $display("FAIL midrun_no_output: got %0d out_valid cycles want 0", highs); end
        send(8'h03, 8'h07, 8'h00);
        wait_out(edges, ok);
        checks++; if (!ok || edges + 1 != W + 1) begin failures++; $display("FAIL midrun_next_latency: got %0d edges want %0d", edges + 1, W + 1); end
        e = exp_q.pop_front();
        checks++; if (p !== e || p !== 16'h0015) begin failures++; $display("FAIL midrun_next_p: got %h want %h", p, e); end
        tick();
    endtask

    task automatic test_back_to_back;
        logic [7:0]  av[3];
        logic [7:0]  bv[3];
        int          acc_cyc[3];
        int          issued;
        int          got;
        int          cyc;
        logic [15:0] e;
        av[0] = 8'h10; bv[0] = 8'h10;
        av[1] = 8'h80; bv[1] = 8'h02;
        av[2] = 8'($urandom); bv[2] = 8'($urandom);
        issued = 0;
        got    = 0;
        cyc    = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        while (got < 3 && cyc < 300) begin
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL b2b_unexpected_output: got p=%h want no output", p);
                end else begin
                    e = exp_q.pop_front();
                    if (p !== e) begin failures++; $display("FAIL b2b_p[%0d]: got %h want %h", got, p, e); end
                end
                got++;
            end
            if (in_ready && issued < 3) begin
                in_valid = 1'b1;
                a = av[issued];
                b = bv[issued];
                r = 8'h00;
                exp_q.push_back(model(av[issued], bv[issued], 8'h00));
                acc_cyc[issued] = cyc;
                issued++;
            end else if (in_ready) begin
                in_valid = 1'b0;
            end else begin
                a = 8'($urandom);
                b = 8'($urandom);
                r = 8'($urandom);
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        checks++; if (got != 3 || issued != 3) begin failures++; $display("FAIL b2b_count: got %0d results from %0d issued want 3/3", got, issued); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_leftover: got %0d pending want 0", exp_q.size()); end
        checks++; if (issued == 3 && (acc_cyc[1] - acc_cyc[0] != W + 2 || acc_cyc[2] - acc_cyc[1] != W + 2)) begin
            failures++; $display("FAIL b2b_spacing: got %0d/%0d cycles want %0d", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1], W + 2);
        end
        tick();
    endtask

    task automatic test_mul_add_rem;
        int          edges;
        bit          ok;
        logic [15:0] e;
        logic [15:0] want;
        logic [7:0]  av;
        logic [7:0]  bv;
        logic [7:0]  rv;
        out_ready = 1'b1;
        want = ADDREM ? 16'hFF00 : 16'hFE01;
        send(8'hFF, 8'hFF, 8'hFF);
        wait_out(edges, ok);
        checks++; if (!ok) begin failures++; $display("FAIL addrem_max_timeout: out_valid never rose"); end
        e = exp_q.pop_front();
        checks++; if (p !== e || p !== want) begin failures++; $display("FAIL addrem_max_p: got %h want %h", p, want); end
        tick();
        for (int i = 0; i < 8; i++) begin
            av = 8'($urandom);
            bv = 8'($urandom_range(1, 255));
            rv = 8'($urandom_range(0, int'(bv) - 1));
            send(av, bv, rv);
            wait_out(edges, ok);
            checks++; if (!ok || edges + 1 != W + 1) begin failures++; $display("FAIL rand_latency[%0d]: got %0d edges want %0d", i, edges + 1, W + 1); end
            e = exp_q.pop_front();
            checks++; if (p !== e) begin failures++; $display("FAIL rand_p[%0d]: got %h want %h", i, p, e); end
            checks++; if (p / {8'h00, bv} !== {8'h00, av} || p % {8'h00, bv} !== (ADDREM ? {8'h00, rv} : 16'h0000)) begin
                failures++; $display("FAIL rand_divide_back[%0d]: got q=%h rem=%h want q=%h", i, p / {8'h00, bv}, p % {8'h00, bv}, av);
            end
            tick();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        r         = 8'h00;
        @(negedge clk);
        test_reset();
        test_basic();
        test_zero_identity();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_mul_add_rem();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
